img_dmem_streamer: RTL
======================

// Module: img_dmem_streamer
// PURPOSE
//  Reads a captured 28x28 image back out of data memory and emits it as a pixel stream.
//  Memory layout: 49 x 256-bit words, 16 x 16-bit pixels per word, lane 0 = bits[15:0].
//  Pixels leave in raster order over a valid/ready interface with SOF/EOF/SOL/EOL flags.
//  Downstream consumers are the SPART dump path and the display overlay.
// PARAMETERS
//  IMG_W        28   pixels per line
//  IMG_H        28   lines per frame
//  PXL_W        16   bits per pixel
//  PXL_PER_WORD 16   pixels packed per dmem word
//  DMEM_AW      7    dmem address width
//  BASE_ADDR    0    dmem address of pixel 0
// PORTS
//  pxlclk       in   1    pixel clock; all logic on its rising edge
//  rst_n        in   1    asynchronous, active-low reset
//  iStart       in   1    pulse; starts one frame read-out when idle
//  iAbort       in   1    terminate the current frame immediately
//  oDmem_rden   out  1    dmem read enable
//  oDmem_addr   out  7    dmem read address
//  iDmem_data   in   256  dmem read data, valid exactly 1 cycle after rden
//  oPxl_data    out  16   pixel value
//  oPxl_valid   out  1    oPxl_data and flags valid
//  iPxl_ready   in   1    consumer accepts the pixel when valid & ready
//  oPxl_sof     out  1    pixel 0 of frame
//  oPxl_eof     out  1    pixel 783 of frame
//  oPxl_sol     out  1    column 0
//  oPxl_eol     out  1    column 27
//  oBusy        out  1    frame in progress
//  oDone        out  1    1-cycle pulse after the pixel-783 handshake
// BEHAVIOUR
//  - Reset values: all outputs 0, oDmem_addr = BASE_ADDR, buffers empty, pxl_cnt = 0.
//  - FSM IDLE -> FETCH -> STREAM -> DONE -> IDLE.
//  - IDLE: on iStart go to FETCH and set oBusy. iStart is ignored in every other state.
//  - FETCH: issue rden for word 0. Move to STREAM when word 0 lands in the buffer.
//    First oPxl_valid appears 2 cycles after iStart.
//  - STREAM: 2-entry word buffer (ping-pong).
//    - A read is issued whenever an entry is free or will free this cycle, and words remain.
//    - Requirement: with iPxl_ready held 1, output is 1 pixel per cycle with no bubbles across word boundaries.
//  - Handshake:
//    - oPxl_data and the flags are held stable while valid & !ready.
//    - oPxl_valid never drops without a handshake, except on abort or reset.
//  - Counters:
//    - pxl_cnt 0..783 advances on each handshake. lane = pxl_cnt[3:0]; word = pxl_cnt[9:4].
//    - col 0..27 and row 0..27 wrap col->0, row+1 at col 27.
//    - sol = (col==0), eol = (col==27), sof = (pxl_cnt==0), eof = (pxl_cnt==783).
//  - Reads: word addr = BASE_ADDR + rd_idx, rd_idx 0..48. Exactly 49 reads per frame; never a 50th.
//  - DONE: the 784th handshake moves to DONE. DONE pulses oDone for 1 cycle, clears oBusy, returns to IDLE.
//    A new iStart is accepted the following cycle.
//  - iAbort, in any state except IDLE, takes effect on the next edge:
//    - valid deasserts, buffers flush, return to IDLE;
//    - no oDone;
//    - any in-flight read data is discarded.
//    iAbort has priority over iStart in the same cycle.
//  - Asynchronous reset mid-frame clears everything. No partial oDone.
//  - Ready deasserted for many cycles: the buffer fills (2 words), then rden stays low. No overrun.
// STRUCTURE
//  - Package img_pkg: IMG_W, IMG_H, PXL_PER_WORD, WORDS_PER_IMG (=49), PIXELS_PER_IMG (=784),
//    and the typedef streamer_state_t {IDLE, FETCH, STREAM, DONE}.
//    The capture FSM uses the same package constants.
//  - Sub-module img_word_buf2: 2-entry 256-bit FIFO (push, pop, full, empty, count, flush),
//    with lane select by pxl_cnt[3:0] in the top level.
// TESTING
//  - Memory preloaded with pixel p = 16'hA000+p, iStart pulse, ready=1:
//    784 pixels in 784 consecutive cycles, 0xA000..0xA30F.
//    sof on the first pixel, eof on the last, oDone 1 cycle later.
//  - Ready toggling 1-0-1-0 at random (seed 7):
//    identical data order, no pixel duplicated or dropped, data stable while stalled,
//    exactly 49 rden pulses.
//  - Ready held 0 for 100 cycles after the first valid:
//    at most 2 rden pulses outstanding, pixel 0 held, stream resumes correctly.
//  - Check sol/eol on pixels 0, 27, 28, 55, 756, 783. Check row 27 ends at eof.
//  - iAbort at pixel 300: valid low next cycle, no oDone.
//    A fresh iStart then replays from pixel 0 with addr = BASE_ADDR.
//  - rst_n pulse mid-frame, and iStart while busy:
//    outputs at reset values; the second iStart is ignored (single frame, single oDone).

Source files
------------

// File: rtl/img_pkg.sv
// Shared image geometry, dmem packing constants and streamer types.
// The capture FSM uses the same constants, so both sides agree on the memory layout.
package img_pkg;

    localparam int unsigned IMG_W          = 28;
    localparam int unsigned IMG_H          = 28;
    localparam int unsigned PXL_W          = 16;
    localparam int unsigned PXL_PER_WORD   = 16;
    localparam int unsigned WORD_W         = PXL_W * PXL_PER_WORD;
    localparam int unsigned PIXELS_PER_IMG = IMG_W * IMG_H;
    localparam int unsigned WORDS_PER_IMG  = (PIXELS_PER_IMG + PXL_PER_WORD - 1) / PXL_PER_WORD;
    localparam int unsigned DMEM_AW        = 7;
    localparam int unsigned CNT_W          = $clog2(PIXELS_PER_IMG);
    localparam int unsigned COORD_W        = $clog2(IMG_W > IMG_H ? IMG_W : IMG_H);
    localparam int unsigned RDIDX_W        = $clog2(WORDS_PER_IMG + 1);
    localparam int unsigned LANE_W         = $clog2(PXL_PER_WORD);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } streamer_state_t;

    // One pixel beat on the output stream.
    typedef struct packed {
        logic [PXL_W-1:0] data;
        logic             sof;
        logic             eof;
        logic             sol;
        logic             eol;
    } pxl_beat_t;

endpackage

// File: rtl/img_word_buf2.sv
// Two-entry ping-pong FIFO of dmem words feeding the pixel lane selector.
// A push and a pop on an empty buffer is a pass-through: the word is consumed directly.
module img_word_buf2
    import img_pkg::*;
(
    input  logic              pxlclk,
    input  logic              rst_n,
    input  logic              iPush,
    input  logic              iPop,
    input  logic              iFlush,
    input  logic [WORD_W-1:0] iData,
    output logic [WORD_W-1:0] oHead_c,
    output logic              oFull_c,
    output logic              oEmpty_c,
    output logic [1:0]        oCount
);

    logic [WORD_W-1:0] mem [2];
    logic              wrPtr;
    logic              rdPtr;
    logic              passThru_c;
    logic              doPush_c;
    logic              doPop_c;

    assign oEmpty_c   = (oCount == 2'd0);
    assign oFull_c    = (oCount == 2'd2);
    assign oHead_c    = mem[rdPtr];
    assign passThru_c = iPush && iPop && oEmpty_c;
    assign doPush_c   = iPush && (!oFull_c || iPop) && !passThru_c;
    assign doPop_c    = iPop && !oEmpty_c;

    always_ff @(posedge pxlclk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            oCount <= 2'd0;
        end else if (iFlush) begin
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            oCount <= 2'd0;
        end else begin
            if (doPush_c) wrPtr <= ~wrPtr;
            if (doPop_c)  rdPtr <= ~rdPtr;
            oCount <= oCount + 2'(doPush_c) - 2'(doPop_c);
        end
    end

    // Word storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge pxlclk) begin
        if (doPush_c && !iFlush) mem[wrPtr] <= iData;
    end

endmodule

// File: rtl/img_dmem_streamer.sv
// Reads a 28x28 image out of dmem (16 pixels per 256-bit word) and emits it as a
// raster-order valid/ready pixel stream with frame and line markers.
module img_dmem_streamer
    import img_pkg::*;
#(
    parameter logic [DMEM_AW-1:0] BASE_ADDR = '0
) (
    input  logic               pxlclk,
    input  logic               rst_n,
    input  logic               iStart,
    input  logic               iAbort,
    output logic               oDmem_rden,
    output logic [DMEM_AW-1:0] oDmem_addr,
    input  logic [WORD_W-1:0]  iDmem_data,
    output logic [PXL_W-1:0]   oPxl_data,
    output logic               oPxl_valid,
    input  logic               iPxl_ready,
    output logic               oPxl_sof,
    output logic               oPxl_eof,
    output logic               oPxl_sol,
    output logic               oPxl_eol,
    output logic               oBusy,
    output logic               oDone
);

    streamer_state_t state;
    logic [RDIDX_W-1:0] rdIdx;
    logic [CNT_W-1:0]   pxlCnt;
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
    logic               datValid;

    logic [WORD_W-1:0]  bufHead_c;
    logic               bufFull_c;
    logic               bufEmpty_c;
    logic [1:0]         bufCount;

    logic               active_c;
    logic               handshake_c;
    logic               srcAvail_c;
    logic [WORD_W-1:0]  srcWord_c;
    logic [PXL_PER_WORD-1:0][PXL_W-1:0] srcLanes_c;
    logic [LANE_W-1:0]  lane_c;
    logic               loadPxl_c;
    logic               popWord_c;
    logic               pushWord_c;
    logic               flushBuf_c;
    logic [2:0]         inFlight_c;
    logic               issueRd_c;
    pxl_beat_t          nextBeat_c;

    assign active_c    = (state == FETCH) || (state == STREAM);
    assign handshake_c = oPxl_valid && iPxl_ready;
    assign flushBuf_c  = iAbort && (state != IDLE);

    // A word arriving into an empty buffer is bypassed straight to the output register.
    assign srcAvail_c  = !bufEmpty_c || datValid;
    assign srcWord_c   = bufEmpty_c ? iDmem_data : bufHead_c;
    assign srcLanes_c  = srcWord_c;
    assign lane_c      = pxlCnt[LANE_W-1:0];

    assign loadPxl_c   = active_c && !iAbort && srcAvail_c
                      && (pxlCnt < CNT_W'(PIXELS_PER_IMG))
                      && (!oPxl_valid || iPxl_ready);
    assign popWord_c   = loadPxl_c && (lane_c == LANE_W'(PXL_PER_WORD - 1));
    assign pushWord_c  = active_c && !iAbort && datValid && (!bufFull_c || popWord_c);

    // Words held after this edge plus reads still in flight must never exceed two.
    assign inFlight_c  = 3'(bufCount) + 3'(datValid) + 3'(oDmem_rden) - 3'(popWord_c);
    assign issueRd_c   = active_c && !iAbort
                      && (rdIdx < RDIDX_W'(WORDS_PER_IMG))
                      && (inFlight_c < 3'd2);

    assign nextBeat_c.data = srcLanes_c[lane_c];
    assign nextBeat_c.sof  = (pxlCnt == CNT_W'(0));
    assign nextBeat_c.eof  = (pxlCnt == CNT_W'(PIXELS_PER_IMG - 1));
    assign nextBeat_c.sol  = (col == COORD_W'(0));
    assign nextBeat_c.eol  = (col == COORD_W'(IMG_W - 1));

    img_word_buf2 u_wordBuf (
        .pxlclk   (pxlclk),
        .rst_n    (rst_n),
        .iPush    (pushWord_c),
        .iPop     (popWord_c),
        .iFlush   (flushBuf_c),
        .iData    (iDmem_data),
        .oHead_c  (bufHead_c),
        .oFull_c  (bufFull_c),
        .oEmpty_c (bufEmpty_c),
        .oCount   (bufCount)
    );

    always_ff @(posedge pxlclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oDmem_rden <= 1'b0;
            oDmem_addr <= BASE_ADDR;
            datValid   <= 1'b0;
            rdIdx      <= '0;
            pxlCnt     <= '0;
            col        <= '0;
            row        <= '0;
            oPxl_valid <= 1'b0;
            oPxl_data  <= '0;
            oPxl_sof   <= 1'b0;
            oPxl_eof   <= 1'b0;
            oPxl_sol   <= 1'b0;
            oPxl_eol   <= 1'b0;
        end else begin
            oDone <= 1'b0;
            unique case (state)
                IDLE: begin
                    oDmem_rden <= 1'b0;
                    datValid   <= 1'b0;
                    if (iStart && !iAbort) begin
                        state      <= FETCH;
                        oBusy      <= 1'b1;
                        oDmem_rden <= 1'b1;
                        oDmem_addr <= BASE_ADDR;
                        rdIdx      <= RDIDX_W'(1);
                        pxlCnt     <= '0;
                        col        <= '0;
                        row        <= '0;
                    end
                end

                FETCH, STREAM: begin
                    if (iAbort) begin
                        // Drop everything, including the read whose data is still on its way.
                        state      <= IDLE;
                        oBusy      <= 1'b0;
                        oDmem_rden <= 1'b0;
                        oDmem_addr <= BASE_ADDR;
                        datValid   <= 1'b0;
                        rdIdx      <= '0;
                        pxlCnt     <= '0;
                        col        <= '0;
                        row        <= '0;
                        oPxl_valid <= 1'b0;
                    end else begin
                        datValid   <= oDmem_rden;
                        oDmem_rden <= issueRd_c;
                        if (issueRd_c) begin
                            oDmem_addr <= BASE_ADDR + DMEM_AW'(rdIdx);
                            rdIdx      <= rdIdx + RDIDX_W'(1);
                        end
                        if ((state == FETCH) && datValid) state <= STREAM;

                        if (loadPxl_c) begin
                            oPxl_valid <= 1'b1;
                            oPxl_data  <= nextBeat_c.data;
                            oPxl_sof   <= nextBeat_c.sof;
                            oPxl_eof   <= nextBeat_c.eof;
                            oPxl_sol   <= nextBeat_c.sol;
                            oPxl_eol   <= nextBeat_c.eol;
                            pxlCnt     <= pxlCnt + CNT_W'(1);
                            if (col == COORD_W'(IMG_W - 1)) begin
                                col <= '0;
                                row <= (row == COORD_W'(IMG_H - 1)) ? '0 : row + COORD_W'(1);
                            end else begin
                                col <= col + COORD_W'(1);
                            end
                        end else if (handshake_c) begin
                            oPxl_valid <= 1'b0;
                        end

                        if (handshake_c && oPxl_eof) begin
                            state <= DONE;
                            oDone <= 1'b1;
                            oBusy <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    oDmem_rden <= 1'b0;
                    datValid   <= 1'b0;
                    oPxl_valid <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
